ins_fetcher: RTL and testbench

INS_FETCHER -- requirements
Module: ins_fetcher

---
 rtl/ins_fetcher.sv | 228 ++++++++++++++++++++++
 tb/tb_ins_fetcher.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetcher.sv
// Instruction fetcher: one outstanding I-cache request, static branch prediction, JALR wait.
// Optional RVC support is enabled by defining IFETCH_C_EXT_EN.
module ins_fetcher (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req_valid,
  output logic [31:0] icache_req_addr,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_data,
  output logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic [31:0] predict_nxt_pc,
  input  logic        IFetcher_stall,
  input  logic        IFetcher_clear,
  input  logic [31:0] IFetcher_new_addr,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_addr
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_JWAIT = 2'd3
  } state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pred_q, pred_d;
  logic        ins_ready_q, ins_ready_d;
  logic        req_valid_q, req_valid_d;
  logic        is_jr_q, is_jr_d;
  logic        epoch_q, epoch_d;
  logic        resp_epoch_q, resp_epoch_d;
  logic        out_q, out_d;

  logic [31:0] dec_ins_s;
  logic [31:0] dec_pred_s;
  logic [31:0] dec_len_s;
  logic        dec_jr_s;
  logic        accept_s;

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    imm_j = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    imm_b = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

`ifdef IFETCH_C_EXT_EN
  function automatic logic [31:0] imm_cj(input logic [15:0] i);
    imm_cj = {{21{i[12]}}, i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
  endfunction

  function automatic logic [31:0] imm_cb(input logic [15:0] i);
    imm_cb = {{24{i[12]}}, i[6:5], i[2], i[11:10], i[4:3], 1'b0};
  endfunction
`endif

  // Decode the incoming cache word: instruction, length, prediction and JALR class.
  always_comb begin
    dec_ins_s  = icache_resp_data;
    dec_len_s  = 32'd4;
    dec_jr_s   = 1'b0;
`ifdef IFETCH_C_EXT_EN
    if (icache_resp_data[1:0] != 2'b11) begin
      dec_ins_s = {16'h0000, icache_resp_data[15:0]};
      dec_len_s = 32'd2;
    end else begin
      dec_len_s = 32'd4;
    end
`endif
    dec_pred_s = fetch_pc_q + dec_len_s;
    if (dec_ins_s[6:0] == OP_JAL) begin
      dec_pred_s = fetch_pc_q + imm_j(dec_ins_s);
    end else if (dec_ins_s[6:0] == OP_BRANCH && dec_ins_s[31]) begin
      dec_pred_s = fetch_pc_q + imm_b(dec_ins_s);
    end else if (dec_ins_s[6:0] == OP_JALR) begin
      dec_jr_s = 1'b1;
    end else begin
      dec_jr_s = 1'b0;
    end
`ifdef IFETCH_C_EXT_EN
    // C.J / C.JAL always taken; C.BEQZ / C.BNEZ taken only backwards.
    if (dec_ins_s[1:0] == 2'b01 && dec_ins_s[14:13] == 2'b01) begin
      dec_pred_s = fetch_pc_q + imm_cj(dec_ins_s[15:0]);
    end else if (dec_ins_s[1:0] == 2'b01 && dec_ins_s[15:14] == 2'b11 && dec_ins_s[12]) begin
      dec_pred_s = fetch_pc_q + imm_cb(dec_ins_s[15:0]);
    end else if (dec_ins_s[1:0] == 2'b10 && dec_ins_s[15:13] == 3'b100 &&
                 dec_ins_s[11:7] != 5'd0 && dec_ins_s[6:2] == 5'd0) begin
      dec_jr_s = 1'b1;
    end else begin
      dec_jr_s = dec_jr_s;
    end
`endif
  end

  // A response is ours only if it answers the live request issued in the current epoch.
  assign accept_s = (state_q == S_WAIT) && icache_resp_valid && out_q && (resp_epoch_q == epoch_q);

  // Next-state and output-register logic for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    ins_d        = ins_q;
    pc_d         = pc_q;
    pred_d       = pred_q;
    ins_ready_d  = ins_ready_q;
    req_valid_d  = req_valid_q;
    is_jr_d      = is_jr_q;
    epoch_d      = epoch_q;
    resp_epoch_d = resp_epoch_q;
    out_d        = out_q;
    if (rdy_in) begin
      if (icache_resp_valid) begin
        out_d = 1'b0;
      end else begin
        out_d = out_q;
      end
      case (state_q)
        S_REQ: begin
          if (req_valid_q) begin
            out_d        = 1'b1;
            resp_epoch_d = epoch_q;
            state_d      = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (accept_s) begin
            ins_d       = dec_ins_s;
            pc_d        = fetch_pc_q;
            pred_d      = dec_pred_s;
            is_jr_d     = dec_jr_s;
            ins_ready_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (!IFetcher_stall) begin
            ins_ready_d = 1'b0;
            if (is_jr_q) begin
              state_d = S_JWAIT;
            end else begin
              fetch_pc_d = pred_q;
              state_d    = S_REQ;
            end
          end else begin
            state_d = S_HOLD;
          end
        end
        S_JWAIT: begin
          if (IFetcher_clear) begin
            fetch_pc_d = IFetcher_new_addr & 32'hFFFF_FFFE;
            epoch_d    = ~epoch_q;
            state_d    = S_REQ;
          end else begin
            state_d = S_JWAIT;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
      // A flush overrides everything; any in-flight response becomes stale.
      if (rob_flush) begin
        ins_ready_d = 1'b0;
        fetch_pc_d  = rob_flush_addr & 32'hFFFF_FFFE;
        epoch_d     = ~epoch_q;
        state_d     = S_REQ;
      end else begin
        epoch_d = epoch_d;
      end
      req_valid_d = (state_d == S_REQ) && !out_d;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= 32'h0000_0000;
      ins_q        <= 32'h0000_0000;
      pc_q         <= 32'h0000_0000;
      pred_q       <= 32'h0000_0000;
      ins_ready_q  <= 1'b0;
      req_valid_q  <= 1'b0;
      is_jr_q      <= 1'b0;
      epoch_q      <= 1'b0;
      resp_epoch_q <= 1'b0;
      out_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      ins_q        <= ins_d;
      pc_q         <= pc_d;
      pred_q       <= pred_d;
      ins_ready_q  <= ins_ready_d;
      req_valid_q  <= req_valid_d;
      is_jr_q      <= is_jr_d;
      epoch_q      <= epoch_d;
      resp_epoch_q <= resp_epoch_d;
      out_q        <= out_d;
    end
  end

  assign icache_req_valid = req_valid_q;
  assign icache_req_addr  = fetch_pc_q;
  assign ins_ready        = ins_ready_q;
  assign ins              = ins_q;
  assign pc               = pc_q;
  assign predict_nxt_pc   = pred_q;

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher: decode/prediction vector table plus hand-written
// sequences for stall, JALR wait, flush-in-WAIT and reset-in-WAIT.
module tb_ins_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid = 1'b0;
  logic [31:0] icache_resp_data = 32'h0;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] pc;
  logic [31:0] predict_nxt_pc;
  logic        IFetcher_stall = 1'b0;
  logic        IFetcher_clear = 1'b0;
  logic [31:0] IFetcher_new_addr = 32'h0;
  logic        rob_flush = 1'b0;
  logic [31:0] rob_flush_addr = 32'h0;

  int tests = 0;
  int fails = 0;

  ins_fetcher dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .icache_resp_valid(icache_resp_valid), .icache_resp_data(icache_resp_data),
    .ins_ready(ins_ready), .ins(ins), .pc(pc), .predict_nxt_pc(predict_nxt_pc),
    .IFetcher_stall(IFetcher_stall), .IFetcher_clear(IFetcher_clear),
    .IFetcher_new_addr(IFetcher_new_addr),
    .rob_flush(rob_flush), .rob_flush_addr(rob_flush_addr)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] flush_addr;
    logic [31:0] req_addr;
    logic [31:0] data;
    logic [31:0] exp_ins;
    logic [31:0] exp_pred;
  } vec_t;

`ifdef IFETCH_C_EXT_EN
  localparam int NVEC = 9;
`else
  localparam int NVEC = 7;
`endif
  vec_t vec [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp_addr);
    int n = 0;
    while (!icache_req_valid && n < 20) begin
      tick;
      n++;
    end
    check({name, " req_valid"}, {31'b0, icache_req_valid}, 32'd1);
    check({name, " req_addr"}, icache_req_addr, exp_addr);
  endtask

  task automatic respond(input logic [31:0] d);
    tick;
    icache_resp_valid = 1'b1;
    icache_resp_data  = d;
    tick;
    icache_resp_valid = 1'b0;
    icache_resp_data  = 32'h0;
  endtask

  task automatic do_flush(input logic [31:0] a);
    rob_flush      = 1'b1;
    rob_flush_addr = a;
    tick;
    rob_flush      = 1'b0;
  endtask

  task automatic check_present(input string name, input logic [31:0] e_ins,
                               input logic [31:0] e_pc, input logic [31:0] e_pred);
    check({name, " ins_ready"}, {31'b0, ins_ready}, 32'd1);
    check({name, " ins"}, ins, e_ins);
    check({name, " pc"}, pc, e_pc);
    check({name, " pred"}, predict_nxt_pc, e_pred);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{32'h0000_0100, 32'h0000_0100, 32'hFE00_0CE3, 32'hFE00_0CE3, 32'h0000_00F8};
    vec[1] = '{32'h0000_0101, 32'h0000_0100, 32'h0000_0463, 32'h0000_0463, 32'h0000_0104};
    vec[2] = '{32'h0000_0040, 32'h0000_0040, 32'h0080_00EF, 32'h0080_00EF, 32'h0000_0048};
    vec[3] = '{32'h0000_0010, 32'h0000_0010, 32'hFF9F_F06F, 32'hFF9F_F06F, 32'h0000_0008};
    vec[4] = '{32'h0000_0004, 32'h0000_0004, 32'hFE00_4CE3, 32'hFE00_4CE3, 32'hFFFF_FFFC};
    vec[5] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0013, 32'h0000_0013, 32'h0000_0000};
`ifdef IFETCH_C_EXT_EN
    vec[6] = '{32'h0000_0010, 32'h0000_0010, 32'h0013_0001, 32'h0000_0001, 32'h0000_0012};
    vec[7] = '{32'h0000_0020, 32'h0000_0020, 32'h0000_A001, 32'h0000_A001, 32'h0000_0020};
    vec[8] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_D001, 32'h0000_D001, 32'h0000_0100};
`else
    vec[6] = '{32'h0000_0010, 32'h0000_0010, 32'h0013_0001, 32'h0013_0001, 32'h0000_0014};
`endif

    // Reset state
    #1;
    tick;
    tick;
    check("rst req_valid", {31'b0, icache_req_valid}, 32'd0);
    check("rst ins_ready", {31'b0, ins_ready}, 32'd0);
    check("rst ins", ins, 32'h0);
    check("rst pc", pc, 32'h0);
    check("rst pred", predict_nxt_pc, 32'h0);
    check("rst req_addr", icache_req_addr, 32'h0);
    rst_in = 1'b0;

    // Boot fetch from 0, then sequential fetch
    wait_req("boot", 32'h0);
    respond(32'h0000_0013);
    check_present("boot", 32'h0000_0013, 32'h0, 32'h4);
    wait_req("seq", 32'h4);
    respond(32'h0000_0013);

    // Prediction vectors
    for (int i = 0; i < NVEC; i++) begin
      do_flush(vec[i].flush_addr);
      wait_req($sformatf("vec%0d", i), vec[i].req_addr);
      respond(vec[i].data);
      check_present($sformatf("vec%0d", i), vec[i].exp_ins, vec[i].req_addr, vec[i].exp_pred);
    end

    // Stall holds presentation; clear outside JWAIT ignored; rdy_in low freezes
    IFetcher_stall    = 1'b1;
    IFetcher_clear    = 1'b1;
    IFetcher_new_addr = 32'h0000_0500;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("stall ins", ins, vec[NVEC-1].exp_ins);
      check("stall pc", pc, vec[NVEC-1].req_addr);
      check("stall req_valid", {31'b0, icache_req_valid}, 32'd0);
    end
    IFetcher_clear = 1'b0;
    rdy_in         = 1'b0;
    IFetcher_stall = 1'b0;
    tick;
    tick;
    check("rdy ins_ready", {31'b0, ins_ready}, 32'd1);
    check("rdy req_valid", {31'b0, icache_req_valid}, 32'd0);
    rdy_in = 1'b1;
    tick;
    check("unstall req_valid", {31'b0, icache_req_valid}, 32'd1);
    check("unstall req_addr", icache_req_addr, vec[NVEC-1].exp_pred);
    respond(32'h0000_0013);

    // JALR waits for the decoder's target
    do_flush(32'h0000_0200);
    wait_req("jalr", 32'h0000_0200);
    respond(32'h0000_80E7);
    check_present("jalr", 32'h0000_80E7, 32'h0000_0200, 32'h0000_0204);
    tick;
    check("jwait ins_ready", {31'b0, ins_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("jwait req_valid", {31'b0, icache_req_valid}, 32'd0);
      tick;
    end
    IFetcher_clear    = 1'b1;
    IFetcher_new_addr = 32'h0000_0345;
    tick;
    IFetcher_clear = 1'b0;
    check("clear req_valid", {31'b0, icache_req_valid}, 32'd1);
    check("clear req_addr", icache_req_addr, 32'h0000_0344);

    // Flush during WAIT: stale response dropped, single outstanding request
    tick;
    do_flush(32'h0000_0080);
    check("flush one-outstanding", {31'b0, icache_req_valid}, 32'd0);
    tick;
    check("flush one-outstanding 2", {31'b0, icache_req_valid}, 32'd0);
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'h0000_0463;
    tick;
    icache_resp_valid = 1'b0;
    icache_resp_data  = 32'h0;
    check("stale ins_ready", {31'b0, ins_ready}, 32'd0);
    wait_req("flush", 32'h0000_0080);
    respond(32'h0000_0013);
    check_present("flush", 32'h0000_0013, 32'h0000_0080, 32'h0000_0084);

    // Reset while WAIT: pending response discarded, restart at 0
    do_flush(32'h0000_0300);
    wait_req("rstwait", 32'h0000_0300);
    tick;
    rst_in = 1'b1;
    #1;
    check("async rst req_valid", {31'b0, icache_req_valid}, 32'd0);
    check("async rst ins_ready", {31'b0, ins_ready}, 32'd0);
    check("async rst pc", pc, 32'h0);
    tick;
    rst_in            = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'h0000_006F;
    tick;
    icache_resp_valid = 1'b0;
    icache_resp_data  = 32'h0;
    check("rstwait ins_ready", {31'b0, ins_ready}, 32'd0);
    wait_req("rstwait boot", 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
